pipeline_controller: RTL and testbench

Control unit for the 5-stage (IF/ID/EX/MEM/WB) RV32I core; it replaces the single-cycle controller once the datapath is pipelined. It decodes the IF/ID instruction and carries the control bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use and RAW hazards, generates stall, flush and forwarding selects, and adds AUIPC, JALR and LUI pass-through support.

---
 rtl/ctrl_pkg.sv | 71 +++++++
 rtl/ctrl_decode.sv | 110 +++++++++++
 rtl/pipeline_controller.sv | 116 +++++++++++
 tb/tb_pipeline_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the pipelined RV32I control unit.
package ctrl_pkg;

  localparam int RA_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SLL    = 4'd1,
    ALU_SLT    = 4'd2,
    ALU_SLTU   = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SRL    = 4'd5,
    ALU_SRA    = 4'd6,
    ALU_OR     = 4'd7,
    ALU_AND    = 4'd8,
    ALU_SUB    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB = 2'd2;

  typedef struct packed {
    alu_op_t         alu_op;
    logic            sel_A;
    logic            sel_B;
    logic [2:0]      br_type;
    logic            branch;
    logic            jump;
    logic            rd_en;
    logic            wr_en;
    logic [2:0]      mask;
    logic            reg_wr;
    logic [1:0]      wb_sel;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            rs1_used;
    logic            rs2_used;
  } ctrl_t;

  // funct3 -> ALU op; alt (funct7[5]) picks sub only for register-register ops.
  function automatic alu_op_t alu_from_f3(logic [2:0] f3, logic alt, logic is_reg);
    case (f3)
      3'd0:    return (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I instruction decoder producing the control bundle.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        legal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            alt;
  logic [RA_W-1:0] rd;
  logic [RA_W-1:0] rs1;
  logic [RA_W-1:0] rs2;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign alt    = instr[30];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Unused source fields stay zero so hazard/forward compares never see stray immediate bits.
  always_comb begin
    ctrl  = '0;
    legal = 1'b1;
    case (opcode)
      OP_R: begin
        ctrl.alu_op   = alu_from_f3(f3, alt, 1'b1);
        ctrl.sel_A    = 1'b1;
        ctrl.reg_wr   = 1'b1;
        ctrl.rd       = rd;
        ctrl.rs1      = rs1;
        ctrl.rs2      = rs2;
        ctrl.rs1_used = 1'b1;
        ctrl.rs2_used = 1'b1;
      end
      OP_I: begin
        ctrl.alu_op   = alu_from_f3(f3, alt, 1'b0);
        ctrl.sel_A    = 1'b1;
        ctrl.sel_B    = 1'b1;
        ctrl.reg_wr   = 1'b1;
        ctrl.rd       = rd;
        ctrl.rs1      = rs1;
        ctrl.rs1_used = 1'b1;
      end
      OP_LOAD: begin
        ctrl.sel_A    = 1'b1;
        ctrl.sel_B    = 1'b1;
        ctrl.rd_en    = 1'b1;
        ctrl.mask     = f3;
        ctrl.reg_wr   = 1'b1;
        ctrl.wb_sel   = WB_MEM;
        ctrl.rd       = rd;
        ctrl.rs1      = rs1;
        ctrl.rs1_used = 1'b1;
      end
      OP_STORE: begin
        ctrl.sel_A    = 1'b1;
        ctrl.sel_B    = 1'b1;
        ctrl.wr_en    = 1'b1;
        ctrl.mask     = f3;
        ctrl.rs1      = rs1;
        ctrl.rs2      = rs2;
        ctrl.rs1_used = 1'b1;
        ctrl.rs2_used = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.sel_B    = 1'b1;
        ctrl.br_type  = f3;
        ctrl.branch   = 1'b1;
        ctrl.rs1      = rs1;
        ctrl.rs2      = rs2;
        ctrl.rs1_used = 1'b1;
        ctrl.rs2_used = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_op = ALU_PASS_B;
        ctrl.sel_B  = 1'b1;
        ctrl.reg_wr = 1'b1;
        ctrl.rd     = rd;
      end
      OP_AUIPC: begin
        ctrl.sel_B  = 1'b1;
        ctrl.reg_wr = 1'b1;
        ctrl.rd     = rd;
      end
      OP_JAL: begin
        ctrl.sel_B  = 1'b1;
        ctrl.jump   = 1'b1;
        ctrl.reg_wr = 1'b1;
        ctrl.wb_sel = WB_PC4;
        ctrl.rd     = rd;
      end
      OP_JALR: begin
        ctrl.sel_A    = 1'b1;
        ctrl.sel_B    = 1'b1;
        ctrl.jump     = 1'b1;
        ctrl.reg_wr   = 1'b1;
        ctrl.wb_sel   = WB_PC4;
        ctrl.rd       = rd;
        ctrl.rs1      = rs1;
        ctrl.rs1_used = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_controller.sv
// 5-stage RV32I control unit: decode, ID/EX/MEM/WB control registers, stall/flush/forward.
// Build option FWD_EN: EX-stage forwarding with load-use-only stalls; otherwise RAW stalls.
module pipeline_controller
  import ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   instr_d,
  input  logic              valid_d,
  input  logic              br_taken_e,
  output logic [3:0]        alu_op_e,
  output logic              sel_A_e,
  output logic              sel_B_e,
  output logic [2:0]        br_type_e,
  output logic              pc_sel_e,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              rd_en_m,
  output logic              wr_en_m,
  output logic [2:0]        mask_m,
  output logic              reg_wr_w,
  output logic [1:0]        wb_sel_w,
  output logic [REG_AW-1:0] rd_w,
  output logic              stall_d,
  output logic              flush_d,
  output logic              illegal_d
);

  ctrl_t dec_d;
  ctrl_t ctrl_e;
  ctrl_t ctrl_m;
  ctrl_t ctrl_w;
  logic  dec_legal;
  logic  dec_ok;
  logic  valid_e;
  logic  hazard_d;

  ctrl_decode u_decode (
    .instr (instr_d[31:0]),
    .ctrl  (dec_d),
    .legal (dec_legal)
  );

  function automatic logic uses_reg(ctrl_t c, logic [RA_W-1:0] rd);
    return (rd != '0) && ((c.rs1_used && (c.rs1 == rd)) || (c.rs2_used && (c.rs2 == rd)));
  endfunction

`ifdef FWD_EN
  function automatic logic [1:0] fwd_sel(logic [RA_W-1:0] rs);
    if (ctrl_m.reg_wr && (ctrl_m.rd != '0) && (ctrl_m.rd == rs))
      return FWD_MEM;
    else if (ctrl_w.reg_wr && (ctrl_w.rd != '0) && (ctrl_w.rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign hazard_d = dec_ok && ctrl_e.rd_en && uses_reg(dec_d, ctrl_e.rd);
  assign fwd_a_e  = fwd_sel(ctrl_e.rs1);
  assign fwd_b_e  = fwd_sel(ctrl_e.rs2);
`else
  // Without forwarding, wait until the producer has reached WB (write-through regfile).
  assign hazard_d = dec_ok && ((ctrl_e.reg_wr && uses_reg(dec_d, ctrl_e.rd)) ||
                               (ctrl_m.reg_wr && uses_reg(dec_d, ctrl_m.rd)));
  assign fwd_a_e  = FWD_RF;
  assign fwd_b_e  = FWD_RF;
`endif

  assign dec_ok    = valid_d && dec_legal;
  assign illegal_d = valid_d && !dec_legal;
  assign pc_sel_e  = valid_e && (ctrl_e.jump || (ctrl_e.branch && br_taken_e));
  assign flush_d   = pc_sel_e;
  assign stall_d   = hazard_d && !pc_sel_e;

  // ID -> EX boundary: flush, stall and non-instructions all become bubbles.
  always_ff @(posedge clk) begin
    if (rst || pc_sel_e || stall_d || !dec_ok) begin
      ctrl_e  <= '0;
      valid_e <= 1'b0;
    end else begin
      ctrl_e  <= dec_d;
      valid_e <= 1'b1;
    end
  end

  // EX -> MEM -> WB boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_m <= '0;
      ctrl_w <= '0;
    end else begin
      ctrl_m <= ctrl_e;
      ctrl_w <= ctrl_m;
    end
  end

  assign alu_op_e  = ctrl_e.alu_op;
  assign sel_A_e   = ctrl_e.sel_A;
  assign sel_B_e   = ctrl_e.sel_B;
  assign br_type_e = ctrl_e.br_type;
  assign rd_en_m   = ctrl_m.rd_en;
  assign wr_en_m   = ctrl_m.wr_en;
  assign mask_m    = ctrl_m.mask;
  assign reg_wr_w  = ctrl_w.reg_wr;
  assign wb_sel_w  = ctrl_w.wb_sel;
  assign rd_w      = REG_AW'(ctrl_w.rd);

  // Control fields that later stages carry but do not drive out.
  logic unused_fields;
  assign unused_fields = ^{ctrl_m, ctrl_w, ctrl_e.rd_en, ctrl_e.wr_en, ctrl_e.mask,
                           ctrl_e.reg_wr, ctrl_e.wb_sel};

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed scoreboard bench for pipeline_controller (default build and FWD_EN build).
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        br_taken_e;
  logic [3:0]  alu_op_e;
  logic        sel_A_e, sel_B_e;
  logic [2:0]  br_type_e;
  logic        pc_sel_e;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        rd_en_m, wr_en_m;
  logic [2:0]  mask_m;
  logic        reg_wr_w;
  logic [1:0]  wb_sel_w;
  logic [4:0]  rd_w;
  logic        stall_d, flush_d, illegal_d;

  always #5 clk = ~clk;

  pipeline_controller #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .br_taken_e(br_taken_e),
    .alu_op_e(alu_op_e), .sel_A_e(sel_A_e), .sel_B_e(sel_B_e), .br_type_e(br_type_e),
    .pc_sel_e(pc_sel_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .rd_en_m(rd_en_m),
    .wr_en_m(wr_en_m), .mask_m(mask_m), .reg_wr_w(reg_wr_w), .wb_sel_w(wb_sel_w),
    .rd_w(rd_w), .stall_d(stall_d), .flush_d(flush_d), .illegal_d(illegal_d)
  );

  typedef enum int {S_ALU, S_SELA, S_SELB, S_BRT, S_PCSEL, S_FWDA, S_FWDB, S_RDEN, S_WREN,
                    S_MASK, S_REGWR, S_WBSEL, S_RDW, S_STALL, S_FLUSH, S_ILL} sig_t;
  typedef struct {
    int    cyc;
    sig_t  sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_sig(sig_t s);
    case (s)
      S_ALU:   return int'(alu_op_e);
      S_SELA:  return int'(sel_A_e);
      S_SELB:  return int'(sel_B_e);
      S_BRT:   return int'(br_type_e);
      S_PCSEL: return int'(pc_sel_e);
      S_FWDA:  return int'(fwd_a_e);
      S_FWDB:  return int'(fwd_b_e);
      S_RDEN:  return int'(rd_en_m);
      S_WREN:  return int'(wr_en_m);
      S_MASK:  return int'(mask_m);
      S_REGWR: return int'(reg_wr_w);
      S_WBSEL: return int'(wb_sel_w);
      S_RDW:   return int'(rd_w);
      S_STALL: return int'(stall_d);
      S_FLUSH: return int'(flush_d);
      default: return int'(illegal_d);
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle, away from the active edge.
  always @(negedge clk) begin
    if (!done) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          int act;
          act = get_sig(sb[i].sig);
          n_total++;
          if (act == sb[i].val) n_pass++;
          else $display("FAIL %s cyc=%0d actual=%0d expected=%0d", sb[i].name, cyc, act, sb[i].val);
          sb.delete(i);
        end
      end
    end
  end

  task automatic exp_at(input int c, input sig_t s, input int v, input string nm);
    exp_t e;
    e.cyc = c; e.sig = s; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic bt);
    instr_d = ins; valid_d = v; br_taken_e = bt;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  initial begin
    int k;
    logic [31:0] add_5_1_2, sub_6_5_3, or_7_5_4, lw_8, add_9_8_2, beq_1_2, sw_3,
                 addi_x0, add_11_0_0, jalr_1_5, addi_12;
    add_5_1_2  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd5);
    sub_6_5_3  = enc_r(7'h20, 5'd3, 5'd5, 3'd0, 5'd6);
    or_7_5_4   = enc_r(7'h00, 5'd4, 5'd5, 3'd6, 5'd7);
    lw_8       = enc_i(12'd0, 5'd1, 3'd2, 5'd8, 7'b0000011);
    add_9_8_2  = enc_r(7'h00, 5'd2, 5'd8, 3'd0, 5'd9);
    beq_1_2    = {1'b0, 6'd0, 5'd2, 5'd1, 3'd0, 4'b0100, 1'b0, 7'b1100011};
    sw_3       = enc_s(12'd4, 5'd3, 5'd1, 3'd2);
    addi_x0    = enc_i(12'd1, 5'd1, 3'd0, 5'd0, 7'b0010011);
    add_11_0_0 = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd11);
    jalr_1_5   = enc_i(12'd0, 5'd5, 3'd0, 5'd1, 7'b1100111);
    addi_12    = enc_i(12'd2, 5'd0, 3'd0, 5'd12, 7'b0010011);

    rst = 1'b1; instr_d = '0; valid_d = 1'b0; br_taken_e = 1'b0;
    tick(); tick();
    rst = 1'b0;

    n_total++;
    if (stall_d == 1'b0) n_pass++;
    else $display("FAIL post_rst_stall actual=%0d expected=0", stall_d);
    n_total++;
    if (flush_d == 1'b0) n_pass++;
    else $display("FAIL post_rst_flush actual=%0d expected=0", flush_d);
    n_total++;
    if (pc_sel_e == 1'b0) n_pass++;
    else $display("FAIL post_rst_pcsel actual=%0d expected=0", pc_sel_e);
    n_total++;
    if (reg_wr_w == 1'b0) n_pass++;
    else $display("FAIL post_rst_regwr actual=%0d expected=0", reg_wr_w);
    n_total++;
    if (rd_w == 5'd0) n_pass++;
    else $display("FAIL post_rst_rdw actual=%0d expected=0", rd_w);

    // Reset state, then first instruction reaches EX one cycle after rst drops.
    k = cyc;
    exp_at(k, S_ALU, 0, "rst_alu");       exp_at(k, S_SELA, 0, "rst_selA");
    exp_at(k, S_SELB, 0, "rst_selB");     exp_at(k, S_PCSEL, 0, "rst_pcsel");
    exp_at(k, S_FWDA, 0, "rst_fwda");     exp_at(k, S_RDEN, 0, "rst_rden");
    exp_at(k, S_WREN, 0, "rst_wren");     exp_at(k, S_REGWR, 0, "rst_regwr");
    exp_at(k, S_WBSEL, 0, "rst_wbsel");   exp_at(k, S_RDW, 0, "rst_rdw");
    exp_at(k, S_STALL, 0, "rst_stall");   exp_at(k, S_FLUSH, 0, "rst_flush");
    exp_at(k + 1, S_ALU, 0, "add_alu");   exp_at(k + 1, S_SELA, 1, "add_selA");
    exp_at(k + 1, S_SELB, 0, "add_selB");
    exp_at(k + 3, S_REGWR, 1, "add_regwr"); exp_at(k + 3, S_RDW, 5, "add_rdw");
    exp_at(k + 3, S_WBSEL, 0, "add_wbsel");
`ifdef FWD_EN
    exp_at(k + 1, S_STALL, 0, "raw_nostall1"); exp_at(k + 2, S_STALL, 0, "raw_nostall2");
    exp_at(k + 2, S_ALU, 9, "sub_alu");        exp_at(k + 2, S_FWDA, 1, "sub_fwda_mem");
    exp_at(k + 2, S_FWDB, 0, "sub_fwdb");
    exp_at(k + 3, S_ALU, 7, "or_alu");         exp_at(k + 3, S_FWDA, 2, "or_fwda_wb");
    drive(add_5_1_2, 1'b1, 1'b0);
    drive(sub_6_5_3, 1'b1, 1'b0);
    drive(or_7_5_4, 1'b1, 1'b0);
`else
    exp_at(k + 1, S_STALL, 1, "raw_stall1");   exp_at(k + 2, S_STALL, 1, "raw_stall2");
    exp_at(k + 3, S_STALL, 0, "raw_release");
    exp_at(k + 4, S_ALU, 9, "sub_alu");        exp_at(k + 4, S_FWDA, 0, "sub_fwda_off");
    drive(add_5_1_2, 1'b1, 1'b0);
    repeat (3) drive(sub_6_5_3, 1'b1, 1'b0);
`endif
    idle(4);

    // Load-use
    k = cyc;
    exp_at(k + 1, S_STALL, 1, "lu_stall");
    exp_at(k + 2, S_RDEN, 1, "lw_rden");     exp_at(k + 2, S_MASK, 2, "lw_mask");
    exp_at(k + 3, S_WBSEL, 1, "lw_wbsel");   exp_at(k + 3, S_RDW, 8, "lw_rdw");
`ifdef FWD_EN
    exp_at(k + 2, S_STALL, 0, "lu_one_cycle");
    exp_at(k + 3, S_ALU, 0, "lu_add_alu");   exp_at(k + 3, S_FWDA, 2, "lu_fwda_wb");
    drive(lw_8, 1'b1, 1'b0);
    repeat (2) drive(add_9_8_2, 1'b1, 1'b0);
`else
    exp_at(k + 2, S_STALL, 1, "lu_stall2");  exp_at(k + 3, S_STALL, 0, "lu_release");
    exp_at(k + 4, S_FWDA, 0, "lu_fwda_off");
    drive(lw_8, 1'b1, 1'b0);
    repeat (3) drive(add_9_8_2, 1'b1, 1'b0);
`endif
    idle(4);

    // Taken branch squashes the ID and IF instructions
    k = cyc;
    exp_at(k + 1, S_PCSEL, 1, "br_pcsel");  exp_at(k + 1, S_FLUSH, 1, "br_flush");
    exp_at(k + 1, S_STALL, 0, "br_stall");  exp_at(k + 1, S_SELA, 0, "br_selA");
    exp_at(k + 1, S_SELB, 1, "br_selB");    exp_at(k + 1, S_BRT, 0, "br_type");
    exp_at(k + 2, S_PCSEL, 0, "br_after_pcsel");
    exp_at(k + 3, S_WREN, 0, "br_sq_wren1"); exp_at(k + 4, S_WREN, 0, "br_sq_wren2");
    exp_at(k + 4, S_REGWR, 0, "br_sq_regwr1"); exp_at(k + 5, S_REGWR, 0, "br_sq_regwr2");
    drive(beq_1_2, 1'b1, 1'b0);
    drive(sw_3, 1'b1, 1'b1);
    drive(32'h0, 1'b0, 1'b0);
    idle(4);

    // x0 destination never creates a dependency
    k = cyc;
    exp_at(k + 1, S_STALL, 0, "x0_stall");
    exp_at(k + 2, S_FWDA, 0, "x0_fwda");    exp_at(k + 2, S_FWDB, 0, "x0_fwdb");
    exp_at(k + 3, S_RDW, 0, "x0_rdw");
    drive(addi_x0, 1'b1, 1'b0);
    drive(add_11_0_0, 1'b1, 1'b0);
    idle(4);

    // JALR: unconditional redirect, PC+4 writeback
    k = cyc;
    exp_at(k + 1, S_PCSEL, 1, "jalr_pcsel"); exp_at(k + 1, S_FLUSH, 1, "jalr_flush");
    exp_at(k + 1, S_SELA, 1, "jalr_selA");   exp_at(k + 1, S_SELB, 1, "jalr_selB");
    exp_at(k + 3, S_WBSEL, 2, "jalr_wbsel"); exp_at(k + 3, S_RDW, 1, "jalr_rdw");
    exp_at(k + 3, S_REGWR, 1, "jalr_regwr"); exp_at(k + 4, S_REGWR, 0, "jalr_sq_regwr");
    drive(jalr_1_5, 1'b1, 1'b0);
    drive(addi_12, 1'b1, 1'b0);
    drive(32'h0, 1'b0, 1'b0);
    idle(4);

    // Illegal opcode, and the same word with valid_d low
    k = cyc;
    exp_at(k, S_ILL, 1, "ill_flag");
    exp_at(k + 1, S_ILL, 0, "ill_invalid");
    exp_at(k + 3, S_REGWR, 0, "ill_bubble");
    drive(32'h0000_007F, 1'b1, 1'b0);
    drive(32'h0000_007F, 1'b0, 1'b0);
    idle(4);

    // Reset asserted during a load-use stall
    k = cyc;
    exp_at(k + 1, S_STALL, 1, "rs_stall");
    exp_at(k + 2, S_STALL, 0, "rs_cleared");
    exp_at(k + 2, S_RDEN, 0, "rs_rden");
    exp_at(k + 3, S_FWDA, 0, "rs_fwda");
    drive(lw_8, 1'b1, 1'b0);
    rst = 1'b1;
    drive(add_9_8_2, 1'b1, 1'b0);
    rst = 1'b0;
    drive(add_9_8_2, 1'b1, 1'b0);
    idle(5);

    done = 1'b1;
    foreach (sb[i]) begin
      n_total++;
      $display("FAIL %s never_checked due_cyc=%0d expected=%0d", sb[i].name, sb[i].cyc, sb[i].val);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
